fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12: program-counter width in bits (legal range 4..16).
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: advance enable; when 0, all state holds.
REQ-005 SHALL have port instr, input, 4: instruction nibble from the program memory at the current pc.
REQ-006 SHALL have ports c_in and z_in, input, 1 each: carry and zero flags from the ALU.
REQ-007 SHALL have port flag_we, input, 1: flag-register write strobe from the control word.
REQ-008 SHALL have ports pc_inc and pc_load, input, 1 each: PC increment and load strobes from the control word.
REQ-009 SHALL have port load_addr, input, PC_W: jump target.
REQ-010 SHALL have port pc, output, PC_W: program-counter value driven to the program memory.
REQ-011 SHALL have port direccion, output, 7: microcode ROM address {ir[3:0], c_reg, z_reg, fase}.
REQ-012 SHALL have ports ir (output, 4), fase (output, 1) and halted (output, 1).

Function
REQ-013 SHALL implement a phase FSM with states FETCH (fase=0) and EXECUTE (fase=1); with enable=1, FETCH->EXECUTE->FETCH each cycle; with enable=0, the state holds.
REQ-014 SHALL load ir <= instr on a FETCH-state edge with enable=1; ir holds at all other times.
REQ-015 SHALL load c_reg <= c_in and z_reg <= z_in on an EXECUTE-state edge with enable=1 and flag_we=1; flag_we is ignored in FETCH.
REQ-016 SHALL update pc only on EXECUTE-state edges with enable=1, with priority pc_load (pc <= load_addr) > pc_inc (pc <= pc+1) > hold.
REQ-017 SHALL wrap pc from 2^PC_W-1 to 0 on increment, with no flag or error.
REQ-018 SHALL drive direccion combinationally from registered state only: zero latency from the register update, glitch-free relative to instr.
REQ-019 SHALL give pc_load precedence when pc_load and pc_inc are asserted together; pc_inc has no effect in that case.

Reset
REQ-020 SHALL, when reset=1 at a clock edge, set state=FETCH, pc=0, ir=0, c_reg=0, z_reg=0 and halted=0, overriding enable and all strobes.
REQ-021 SHALL, after reset deasserts, start with direccion=7'b0000000.
REQ-022 SHALL abort any pending operation when reset is asserted mid-EXECUTE: no pc or flag update is committed on that edge.

Configuration
REQ-023 SHALL add a HALT state when macro SEQ_HALT_EN is defined: on an EXECUTE edge with enable=1 and ir=4'b1111, the FSM enters HALT, halted=1, and pc, ir, flags and fase (=1) freeze until reset.
REQ-024 SHALL treat opcode 4'b1111 as ordinary when SEQ_HALT_EN is undefined; halted is tied to 0 and no HALT state exists.

Structure
REQ-025 SHALL take the state encoding (FETCH, EXECUTE, HALT), the HALT_OPCODE=4'b1111 constant and the direccion field positions from the shared package seq_pkg.
REQ-026 SHALL be one module with no sub-modules; the microcode ROM is instantiated beside it at the top level, not inside it.

Verification
REQ-027 SHALL verify reset: reset=1 for 2 cycles with pc_load=1 and load_addr=12'h0AB -> pc=0, direccion=7'b0000000, fase=0, halted=0.
REQ-028 SHALL verify fetch/decode: instr=4'b1011 with enable=1 for 2 cycles, c_in=1, z_in=0, flag_we=1 -> after edge 1, direccion=7'b1011001; after edge 2, direccion=7'b1011100.
REQ-029 SHALL verify strobe priority: pc=12'h010 in EXECUTE with pc_load=1, pc_inc=1 and load_addr=12'h3F0 -> pc=12'h3F0 next cycle.
REQ-030 SHALL verify wrap-around: pc=12'hFFF with pc_inc=1 in EXECUTE -> pc=12'h000.
REQ-031 SHALL verify hold: enable=0 for 5 cycles with toggling instr and strobes -> pc, ir, fase and direccion are unchanged.
REQ-032 SHALL verify halt with SEQ_HALT_EN defined: instr=4'b1111 fetched -> halted=1 after the EXECUTE edge, pc frozen for 10 cycles, cleared by reset; without the macro, the same stimulus gives halted=0 and pc keeps advancing.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, halt opcode and direccion field layout for the fetch sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } seq_state_t;

  localparam logic [3:0] HALT_OPCODE = 4'b1111;

  localparam int DIR_W        = 7;
  localparam int DIR_IR_MSB   = 6;
  localparam int DIR_IR_LSB   = 3;
  localparam int DIR_C_BIT    = 2;
  localparam int DIR_Z_BIT    = 1;
  localparam int DIR_FASE_BIT = 0;

  function automatic logic [DIR_W-1:0] pack_direccion(
    input logic [3:0] ir,
    input logic       c,
    input logic       z,
    input logic       f
  );
    logic [DIR_W-1:0] d;
    d                          = '0;
    d[DIR_IR_MSB:DIR_IR_LSB]   = ir;
    d[DIR_C_BIT]               = c;
    d[DIR_Z_BIT]               = z;
    d[DIR_FASE_BIT]            = f;
    return d;
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-phase fetch/execute sequencer producing the microcode ROM address
// Optional HALT state on opcode 4'b1111 enabled by macro SEQ_HALT_EN.
module fetch_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [3:0]      instr,
  input  logic            c_in,
  input  logic            z_in,
  input  logic            flag_we,
  input  logic            pc_inc,
  input  logic            pc_load,
  input  logic [PC_W-1:0] load_addr,
  output logic [PC_W-1:0] pc,
  output logic [6:0]      direccion,
  output logic [3:0]      ir,
  output logic            fase,
  output logic            halted
);

  seq_state_t      r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [3:0]      r_ir, w_ir_nxt;
  logic            r_c, w_c_nxt;
  logic            r_z, w_z_nxt;
  logic            w_fase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_c     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_c     <= w_c_nxt;
      r_z     <= w_z_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
    case (r_state)
      ST_FETCH: begin
        if (enable) begin
          w_ir_nxt    = instr;
          w_state_nxt = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (enable) begin
          if (flag_we) begin
            w_c_nxt = c_in;
            w_z_nxt = z_in;
          end
          // load wins over increment when both strobes are asserted
          if (pc_load) begin
            w_pc_nxt = load_addr;
          end else if (pc_inc) begin
            w_pc_nxt = r_pc + PC_W'(1);
          end
          w_state_nxt = ST_FETCH;
`ifdef SEQ_HALT_EN
          if (r_ir == HALT_OPCODE) begin
            w_state_nxt = ST_HALT;
          end
`endif
        end
      end
      default: begin
        w_state_nxt = r_state;
      end
    endcase
  end

  assign w_fase    = (r_state != ST_FETCH);
  assign fase      = w_fase;
  assign pc        = r_pc;
  assign ir        = r_ir;
  assign direccion = pack_direccion(r_ir, r_c, r_z, w_fase);

`ifdef SEQ_HALT_EN
  assign halted = (r_state == ST_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed and randomized checks of fetch_sequencer against a behavioural model
// Build with SEQ_HALT_EN defined to exercise the HALT variant.
module tb_fetch_sequencer;

  localparam int PC_W = 12;
  localparam int PC_MOD = 1 << PC_W;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [3:0]      instr;
  logic            c_in;
  logic            z_in;
  logic            flag_we;
  logic            pc_inc;
  logic            pc_load;
  logic [PC_W-1:0] load_addr;
  logic [PC_W-1:0] pc;
  logic [6:0]      direccion;
  logic [3:0]      ir;
  logic            fase;
  logic            halted;

  int n_tests;
  int n_fail;

  int m_phase;
  int m_pc;
  int m_ir;
  int m_c;
  int m_z;
  int m_halt;

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .instr     (instr),
    .c_in      (c_in),
    .z_in      (z_in),
    .flag_we   (flag_we),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .load_addr (load_addr),
    .pc        (pc),
    .direccion (direccion),
    .ir        (ir),
    .fase      (fase),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the sequencer as described behaviourally: a fetch latches the
  // instruction, an execute commits flags and the pc, and a halt freezes everything.
  task automatic model_step();
    if (reset) begin
      m_phase = 0; m_pc = 0; m_ir = 0; m_c = 0; m_z = 0; m_halt = 0;
    end else if (m_halt == 0 && enable) begin
      if (m_phase == 0) begin
        m_ir    = int'(instr);
        m_phase = 1;
      end else begin
        if (flag_we) begin
          m_c = int'(c_in);
          m_z = int'(z_in);
        end
        if (pc_load)     m_pc = int'(load_addr);
        else if (pc_inc) m_pc = (m_pc + 1) % PC_MOD;
        m_phase = 0;
`ifdef SEQ_HALT_EN
        if (m_ir == 15) begin
          m_halt  = 1;
          m_phase = 1;
        end
`endif
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check_eq({tag, ".ir"}, 32'(ir), 32'(m_ir));
    check_eq({tag, ".fase"}, 32'(fase), 32'(m_phase));
    check_eq({tag, ".halted"}, 32'(halted), 32'(m_halt));
    check_eq({tag, ".dir"}, 32'(direccion), 32'(m_ir * 8 + m_c * 4 + m_z * 2 + m_phase));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
  endtask

  task automatic set_in(input logic [3:0] i, input logic ci, input logic zi, input logic fw,
                        input logic inc, input logic ld, input logic [PC_W-1:0] addr);
    instr = i; c_in = ci; z_in = zi; flag_we = fw; pc_inc = inc; pc_load = ld; load_addr = addr;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] i, input logic inc,
                           input logic ld, input logic [PC_W-1:0] addr);
    set_in(i, 1'b0, 1'b0, 1'b0, inc, ld, addr);
    cyc({tag, ".f"});
    cyc({tag, ".e"});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc("rst");
    reset = 1'b0;
  endtask

  logic [PC_W-1:0] snap_pc;
  logic [3:0]      snap_ir;
  logic            snap_fase;
  logic [6:0]      snap_dir;

  initial begin
    n_tests = 0; n_fail = 0;
    m_phase = 0; m_pc = 0; m_ir = 0; m_c = 0; m_z = 0; m_halt = 0;
    enable = 1'b1;
    reset  = 1'b1;
    set_in(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0AB);
    #2;

    // reset held two cycles overrides active strobes
    cyc("reset0");
    cyc("reset1");
    check_eq("reset.pc", 32'(pc), 32'h0);
    check_eq("reset.dir", 32'(direccion), 32'h0);
    check_eq("reset.fase", 32'(fase), 32'h0);
    check_eq("reset.halted", 32'(halted), 32'h0);
    reset = 1'b0;

    // fetch/decode
    set_in(4'b1011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
    cyc("decode.e1");
    check_eq("decode.dir1", 32'(direccion), 32'b1011001);
    cyc("decode.e2");
    check_eq("decode.dir2", 32'(direccion), 32'b1011100);

    // strobe priority
    run_instr("prio.setup", 4'h2, 1'b0, 1'b1, 12'h010);
    check_eq("prio.pc_setup", 32'(pc), 32'h010);
    run_instr("prio", 4'h3, 1'b1, 1'b1, 12'h3F0);
    check_eq("prio.pc", 32'(pc), 32'h3F0);

    // wrap-around
    run_instr("wrap.setup", 4'h4, 1'b0, 1'b1, 12'hFFF);
    run_instr("wrap", 4'h5, 1'b1, 1'b0, 12'h000);
    check_eq("wrap.pc", 32'(pc), 32'h000);

    // hold with enable low, starting mid-instruction
    set_in(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    cyc("hold.pre");
    snap_pc = pc; snap_ir = ir; snap_fase = fase; snap_dir = direccion;
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom), 12'($urandom));
      cyc("hold");
      check_eq("hold.pc", 32'(pc), 32'(snap_pc));
      check_eq("hold.ir", 32'(ir), 32'(snap_ir));
      check_eq("hold.fase", 32'(fase), 32'(snap_fase));
      check_eq("hold.dir", 32'(direccion), 32'(snap_dir));
    end
    enable = 1'b1;
    set_in(4'h6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
    cyc("hold.post");

    // reset arriving in EXECUTE commits nothing
    run_instr("abort.setup", 4'h7, 1'b0, 1'b1, 12'h123);
    set_in(4'h8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'h055);
    cyc("abort.f");
    reset = 1'b1;
    cyc("abort.e");
    check_eq("abort.pc", 32'(pc), 32'h0);
    check_eq("abort.dir", 32'(direccion), 32'h0);
    reset = 1'b0;

    // halt opcode
    run_instr("halt", 4'hF, 1'b1, 1'b0, 12'h000);
    check_eq("halt.pc", 32'(pc), 32'h001);
`ifdef SEQ_HALT_EN
    check_eq("halt.halted", 32'(halted), 32'h1);
    for (int k = 0; k < 10; k++) begin
      set_in(4'($urandom), 1'($urandom), 1'($urandom), 1'b1, 1'b1, 1'($urandom), 12'($urandom));
      cyc("halt.frozen");
      check_eq("halt.pc_frozen", 32'(pc), 32'h001);
      check_eq("halt.fase", 32'(fase), 32'h1);
    end
    do_reset();
    check_eq("halt.cleared", 32'(halted), 32'h0);
`else
    check_eq("halt.halted", 32'(halted), 32'h0);
    run_instr("halt.again", 4'hF, 1'b1, 1'b0, 12'h000);
    check_eq("halt.pc_adv", 32'(pc), 32'h002);
    check_eq("halt.halted2", 32'(halted), 32'h0);
`endif

    // randomized run against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      enable = ($urandom_range(3) != 0);
      reset  = ($urandom_range(40) == 0);
      set_in(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(4) == 0), 12'($urandom));
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
